// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared UART transmitter.
// master: arbiter side (drives the ready, tx, busy, grant and timeout signals). slave: requesters + transmitter side.
// Signals: port_en/req_valid/req_data/req_last/req_ready per requester, tx_valid/tx_data/tx_ready, busy/grant/timeout.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]   port_en;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;
    logic               busy;
    logic [GW-1:0]      grant;
    logic               timeout;

    modport master (
        input  port_en, req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, busy, grant, timeout
    );

    modport slave (
        output port_en, req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, busy, grant, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; a grant is locked for a whole message, with idle-timeout release.
// Latency: 1 cycle of arbitration (IDLE) before the first byte; bytes then pass combinationally while locked.
// Backpressure: tx_ready is forwarded to the owner's req_ready only; every other requester sees ready low.
// Ports: i_clk, i_rst_n (async active-low), bus (uart_tx_arbiter_if.master) carrying the requester and tx signals.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    uart_tx_arbiter_if.master  bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_FIRE = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [CW-1:0] cnt;
    logic          timeout;

    logic          lock;
    logic          g_valid;
    logic          g_en;
    logic          g_last;
    logic [7:0]    g_data;
    logic          xfer;
    logic          fire;

    logic [N_REQ-1:0] eligible;
    logic [GW-1:0]    scan_idx [N_REQ];
    logic             found;
    logic [GW-1:0]    next_grant;

    // Only the owner's lane is ever selected, so junk on idle lanes cannot leak out.
    assign lock    = (state == LOCK);
    assign g_valid = bus.req_valid[grant];
    assign g_en    = bus.port_en[grant];
    assign g_last  = bus.req_last[grant];
    assign g_data  = bus.req_data[{grant, 3'b000} +: 8];
    assign xfer    = lock & g_valid & g_en & bus.tx_ready;

    // Owner silent for TIMEOUT cycles in a row: counter reached TIMEOUT-1 and valid is still low.
    assign fire = (TIMEOUT != 0) && lock && !g_valid && (cnt == CNT_FIRE);

    assign bus.tx_valid = lock & g_valid & g_en;
    assign bus.tx_data  = lock ? g_data : 8'h00;
    assign bus.busy     = lock;
    assign bus.grant    = grant;
    assign bus.timeout  = timeout;

    always_comb begin
        bus.req_ready = '0;
        if (lock && g_en && bus.tx_ready) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // Scan starts one past the last owner, so a port re-requesting right after
    // its own message goes to the back of the line.
    assign eligible = bus.req_valid & bus.port_en;

    always_comb begin
        found      = 1'b0;
        next_grant = grant;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx[i] = GW'((int'(grant) + i + 1) % N_REQ);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && eligible[scan_idx[i]]) begin
                found      = 1'b1;
                next_grant = scan_idx[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            grant   <= GW'(N_REQ - 1);
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (found) begin
                        grant <= next_grant;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if ((xfer && g_last) || !g_en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (fire) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                        cnt     <= '0;
                    end else if (g_valid || (TIMEOUT == 0)) begin
                        // Valid high (even if stalled on tx_ready) keeps the owner alive.
                        cnt <= '0;
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
